// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the traffic phase sequencer.
// Optional macro: TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN adds the FLASH state.
package traffic_pkg;

`ifdef TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN
  typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALL_RED, FLASH} state_t;
`else
  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALL_RED} state_t;
`endif

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  // Lamp pattern shown by the phase that owns the cycle in a given state.
  function automatic logic [2:0] active_light(input state_t s);
    case (s)
      GREEN:   active_light = LIGHT_GRN;
      YELLOW:  active_light = LIGHT_YEL;
      default: active_light = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Per-state countdown: loads a duration (0 counts as 1), decrements on tick,
// flags expiry when a tick arrives with one tick remaining.
module phase_timer #(
  parameter int TIME_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [TIME_W-1:0] duration,
  input  logic              tick,
  output logic [TIME_W-1:0] time_left,
  output logic              expire
);

  assign expire = tick && (time_left == TIME_W'(1));

  // Countdown register; clear beats load beats decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_left <= '0;
    end else if (clear) begin
      time_left <= '0;
    end else if (load) begin
      time_left <= (duration == '0) ? TIME_W'(1) : duration;
    end else if (tick && (time_left > TIME_W'(1))) begin
      time_left <= time_left - TIME_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-phase round-robin intersection sequencer with pedestrian early cut.
// Optional macro: TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN (flash_mode port, FLASH state).
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int TIME_W     = 6,
  parameter int PED_CUT    = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [NUM_PHASES-1:0]         ped_req,
  input  logic [TIME_W-1:0]             green_time,
  input  logic [TIME_W-1:0]             yellow_time,
  input  logic [TIME_W-1:0]             allred_time,
`ifdef TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN
  input  logic                          flash_mode,
`endif
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [TIME_W-1:0]             time_left,
  output logic [NUM_PHASES-1:0]         walk_pending
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [TIME_W-1:0] PED_CUT_W = TIME_W'(PED_CUT);

  state_t                  state, state_n;
  logic [PW-1:0]           phase_n;
  logic [3*NUM_PHASES-1:0] lights_n;
  logic [NUM_PHASES-1:0]   walk_n, active_mask, next_mask;
  logic                    t_load, t_clear, t_expire, early_cut;
  logic [TIME_W-1:0]       t_dur;
  logic                    flash_on, flash_on_n;

  phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (t_load),
    .clear     (t_clear),
    .duration  (t_dur),
    .tick      (tick),
    .time_left (time_left),
    .expire    (t_expire)
  );

  // One-hot masks of the current and next owning phase.
  always_comb begin
    active_mask = '0;
    next_mask   = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      active_mask[i] = (PW'(i) == active_phase);
      next_mask[i]   = (PW'(i) == phase_n);
    end
  end

  assign early_cut = (state == GREEN) && (|(walk_pending & ~active_mask)) &&
                     (time_left <= PED_CUT_W);

  // Next-state, next-phase and timer load selection.
  always_comb begin
    state_n = state;
    phase_n = active_phase;
    t_load  = 1'b0;
    t_clear = 1'b0;
    t_dur   = '0;
    case (state)
      IDLE: begin
        state_n = GREEN;
        phase_n = '0;
        t_load  = 1'b1;
        t_dur   = green_time;
      end
      GREEN: if (early_cut || t_expire) begin
        state_n = YELLOW;
        t_load  = 1'b1;
        t_dur   = yellow_time;
      end
      YELLOW: if (t_expire) begin
        state_n = ALL_RED;
        t_load  = 1'b1;
        t_dur   = allred_time;
      end
      ALL_RED: if (t_expire) begin
        state_n = GREEN;
        t_load  = 1'b1;
        t_dur   = green_time;
        phase_n = (active_phase == PW'(NUM_PHASES - 1)) ? '0 : active_phase + PW'(1);
      end
`ifdef TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN
      FLASH: if (!flash_mode) begin
        state_n = ALL_RED;
        t_load  = 1'b1;
        t_dur   = allred_time;
        phase_n = PW'(NUM_PHASES - 1);
      end else begin
        t_clear = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
`ifdef TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN
    if (flash_mode && state != FLASH) begin
      state_n = FLASH;
      t_load  = 1'b0;
      t_clear = 1'b1;
    end
`endif
  end

  // Registered outputs are derived from the next state so they change on the same edge.
  always_comb begin
    flash_on_n = flash_on;
`ifdef TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN
    if (state_n == FLASH)
      flash_on_n = (state != FLASH) ? 1'b1 : (tick ? ~flash_on : flash_on);
`endif
    lights_n = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      lights_n[3*i +: 3] = next_mask[i] ? active_light(state_n) : LIGHT_RED;
`ifdef TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN
      if (state_n == FLASH)
        lights_n[3*i +: 3] = flash_on_n ? LIGHT_YEL : LIGHT_OFF;
`endif
    end
    // A request arriving on the edge its phase turns green is served, so clear wins.
    walk_n = (walk_pending | (ped_req & ~((state == GREEN) ? active_mask : '0))) &
             ~(((state_n == GREEN) && (state != GREEN)) ? next_mask : '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      active_phase <= '0;
      lights       <= {NUM_PHASES{LIGHT_RED}};
      walk_pending <= '0;
      flash_on     <= 1'b0;
    end else begin
      state        <= state_n;
      active_phase <= phase_n;
      lights       <= lights_n;
      walk_pending <= walk_n;
      flash_on     <= flash_on_n;
    end
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Parametrised N-phase intersection sequencer that cycles GREEN -> YELLOW -> ALL_RED for each phase in round-robin order.
- Green, yellow and all-red durations are runtime inputs. Each phase has its own latched pedestrian request, and a pending request can shorten the active green.
- Sits between the debouncers/prescaler and the display/PWM drivers; time_left feeds the BCD display path and walk_pending feeds the wait-LED PWM.

Parameters:
- NUM_PHASES, 2, number of phases (2..8).
- TIME_W, 6, width of duration inputs and time_left.
- PED_CUT, 10, early-cut threshold: green may end early once time_left <= PED_CUT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- tick  in  1  one-cycle 1 Hz strobe from the prescaler
- ped_req  in  NUM_PHASES  debounced pedestrian request pulses, one bit per phase
- green_time  in  TIME_W  green duration in ticks
- yellow_time  in  TIME_W  yellow duration in ticks
- allred_time  in  TIME_W  all-red clearance duration in ticks
- lights  out  3*NUM_PHASES  per-phase {R,Y,G}; phase i occupies bits [3i+2:3i]
- active_phase  out  $clog2(NUM_PHASES)  index of the phase owning the cycle
- time_left  out  TIME_W  remaining ticks in the current state
- walk_pending  out  NUM_PHASES  latched pedestrian requests
- flash_mode  in  1  present only with FLASH_MODE_EN

Behaviour:
- Reset: state IDLE, active_phase 0, lights all 3'b100, time_left 0, walk_pending 0.
- All outputs are registered and updated on the same edge as the state.
- States: IDLE, GREEN, YELLOW, ALL_RED (FLASH added with the macro).
- IDLE -> GREEN unconditionally on the first clock; loads green_time; active_phase = 0.
- Duration load: on entering a state, time_left = duration. A duration of 0 is treated as 1.
- Config inputs are sampled only at state entry. Changes mid-state take effect at the next entry.
- Countdown: on tick, if time_left == 1, transition and load the next duration; otherwise decrement. No tick: hold.
- GREEN -> YELLOW on expiry, loads yellow_time.
- YELLOW -> ALL_RED on expiry, loads allred_time.
- ALL_RED -> GREEN on expiry, loads green_time; active_phase increments and wraps NUM_PHASES-1 -> 0.
- Early cut:
  - Condition: in GREEN, any walk_pending bit other than active_phase is set and time_left <= PED_CUT.
  - Action: next clock goes to YELLOW, no tick required.
  - Early cut has priority over a simultaneous tick.
- Light encoding:
  - Active phase: GREEN 3'b001, YELLOW 3'b010, ALL_RED 3'b100.
  - Non-active phases: always 3'b100.
  - Never more than one phase non-red.
- walk_pending[i]:
  - Set by ped_req[i].
  - Cleared on the edge phase i enters GREEN.
  - ped_req[i] while phase i is in GREEN is ignored.
  - Set and clear in the same cycle: clear wins, because the request is served.
- Reset mid-operation returns immediately to the reset values; pending requests are lost.

Optional Feature:
- Macro: TRAFFIC_PHASE_SEQUENCER_FLASH_MODE_EN.
- With macro:
  - Adds port flash_mode and state FLASH.
  - flash_mode = 1 in any state enters FLASH on the next clock.
  - In FLASH, all phases show 3'b010 and 3'b000 alternately, toggling on each tick and starting at 3'b010.
  - time_left is 0 in FLASH. walk_pending still latches.
  - On flash_mode = 0: go to ALL_RED with allred_time loaded and active_phase = NUM_PHASES-1, so the next green is phase 0.
- Without macro: no port and no state; behaviour exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - state_t enum;
  - light constants LIGHT_RED = 3'b100, LIGHT_YEL = 3'b010, LIGHT_GRN = 3'b001, LIGHT_OFF = 3'b000.
- Sub-module phase_timer (load, duration, tick -> time_left, expire) holds the countdown, including the 0-as-1 rule.

Test Plan (NUM_PHASES = 3, green 20, yellow 5, allred 2, PED_CUT 10):
- Reset, free run with ticks -> phase 0 shows G for 20 ticks, Y for 5, R for 2; then phase 1 goes green, then phase 2, then wraps to phase 0. Other phases are red throughout.
- ped_req[2] pulse while phase 0 GREEN at time_left = 15 -> stays GREEN until time_left = 10, then YELLOW on the next clock. walk_pending[2] is held until phase 2 enters GREEN, then clears.
- ped_req[0] during phase 0 GREEN -> walk_pending[0] stays 0 and green runs the full 20 ticks.
- green_time changed 20 -> 8 mid-green -> the current green is unaffected; the next phase's green lasts 8 ticks. yellow_time = 0 -> yellow lasts 1 tick.
- Reset asserted during YELLOW of phase 1 with walk_pending = 3'b101 -> all outputs return to reset values immediately; after release, phase 0 is GREEN with time_left 20.
- (FLASH_MODE_EN) flash_mode = 1 during GREEN -> all lights alternate 3'b010 / 3'b000 on each tick. On release -> ALL_RED for 2 ticks, then phase 0 GREEN.
